// File: rtl/iob_fp_classify_stream.sv
// iob_fp_classify_stream: multi-lane IEEE-754 classifier, one registered
// stage with valid/ready handshake, sticky class flags, event counters.
//
// Ports:
//   clk_i, arst_n_i        clock, async active-low reset
//   clear_i                sync clear of sticky flags and counters
//   valid_i/ready_o        input handshake, data_i holds LANES operands
//   valid_o/ready_i        output handshake, class_o/data_o per lane
//   sticky_o               OR of all classes accepted since reset/clear
//   nan_cnt_o, sub_cnt_o   saturating NaN / subnormal lane counters
//
// Build option: define IOB_FP_CLASSIFY_CNT_EN to implement the counters;
// otherwise both counter ports are tied to zero.

module iob_fp_classify_stream #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic                    clear_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [LANES*DATA_W-1:0] data_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [LANES*10-1:0]     class_o,
    output logic [LANES*DATA_W-1:0] data_o,
    output logic [9:0]              sticky_o,
    output logic [CNT_W-1:0]        nan_cnt_o,
    output logic [CNT_W-1:0]        sub_cnt_o
);

    localparam int FRAC_W = DATA_W - EXP_W - 1;

    // fclass one-hot of a single operand
    function automatic logic [9:0] fclass(input logic [DATA_W-1:0] w);
        logic             sgn;
        logic [EXP_W-1:0] ex;
        logic [FRAC_W-1:0] fr;
        logic             e_max;
        logic             e_zero;
        logic             f_zero;
        logic [9:0]       c;
        sgn    = w[DATA_W-1];
        ex     = w[DATA_W-2 -: EXP_W];
        fr     = w[FRAC_W-1:0];
        e_max  = &ex;
        e_zero = ~|ex;
        f_zero = ~|fr;
        c      = '0;
        unique case (1'b1)
            e_max & ~f_zero &  fr[FRAC_W-1]: c[9] = 1'b1;
            e_max & ~f_zero & ~fr[FRAC_W-1]: c[8] = 1'b1;
            e_max & f_zero:   c[sgn ? 0 : 7] = 1'b1;
            e_zero & f_zero:  c[sgn ? 3 : 4] = 1'b1;
            e_zero & ~f_zero: c[sgn ? 2 : 5] = 1'b1;
            default:          c[sgn ? 1 : 6] = 1'b1;
        endcase
        return c;
    endfunction

    logic                accept;
    logic [LANES*10-1:0] cls;
    logic [9:0]          cls_or;
    logic [9:0]          sticky_q;

    assign ready_o = ~valid_o | ready_i;
    assign accept  = valid_i & ready_o;

    always_comb begin
        cls    = '0;
        cls_or = '0;
        for (int k = 0; k < LANES; k++) begin
            cls[k*10 +: 10] = fclass(data_i[k*DATA_W +: DATA_W]);
            cls_or = cls_or | cls[k*10 +: 10];
        end
    end

    // Output register: load on accept, drop valid on a bare transfer.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            valid_o <= 1'b0;
            class_o <= '0;
            data_o  <= '0;
        end else if (accept) begin
            valid_o <= 1'b1;
            class_o <= cls;
            data_o  <= data_i;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

    // Clear first, then OR in the beat accepted in the same cycle.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sticky_q <= '0;
        end else if (accept) begin
            sticky_q <= (clear_i ? 10'd0 : sticky_q) | cls_or;
        end else if (clear_i) begin
            sticky_q <= '0;
        end
    end

    assign sticky_o = sticky_q;

`ifdef IOB_FP_CLASSIFY_CNT_EN

    localparam int CW = $clog2(LANES + 1);

    logic [CW-1:0]    n_nan;
    logic [CW-1:0]    n_sub;
    logic [CNT_W:0]   nan_sum;
    logic [CNT_W:0]   sub_sum;
    logic [CNT_W-1:0] nan_next;
    logic [CNT_W-1:0] sub_next;
    logic [CNT_W-1:0] nan_q;
    logic [CNT_W-1:0] sub_q;

    always_comb begin
        n_nan = '0;
        n_sub = '0;
        for (int k = 0; k < LANES; k++) begin
            n_nan = n_nan + CW'(cls[k*10+8] | cls[k*10+9]);
            n_sub = n_sub + CW'(cls[k*10+2] | cls[k*10+5]);
        end
    end

    // Extra top bit catches the carry; on carry the count pins at max.
    always_comb begin
        nan_sum  = {1'b0, (clear_i ? {CNT_W{1'b0}} : nan_q)}
                 + (CNT_W+1)'(n_nan);
        sub_sum  = {1'b0, (clear_i ? {CNT_W{1'b0}} : sub_q)}
                 + (CNT_W+1)'(n_sub);
        nan_next = nan_sum[CNT_W] ? {CNT_W{1'b1}} : nan_sum[CNT_W-1:0];
        sub_next = sub_sum[CNT_W] ? {CNT_W{1'b1}} : sub_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            nan_q <= '0;
            sub_q <= '0;
        end else if (accept) begin
            nan_q <= nan_next;
            sub_q <= sub_next;
        end else if (clear_i) begin
            nan_q <= '0;
            sub_q <= '0;
        end
    end

    assign nan_cnt_o = nan_q;
    assign sub_cnt_o = sub_q;

`else

    assign nan_cnt_o = '0;
    assign sub_cnt_o = '0;

`endif

endmodule

// File: tb/tb_iob_fp_classify_stream.sv
// Directed bench for iob_fp_classify_stream (LANES=4, CNT_W=4).
// Expected counter values follow the IOB_FP_CLASSIFY_CNT_EN build setting.

module tb_iob_fp_classify_stream;

`ifdef IOB_FP_CLASSIFY_CNT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    localparam int DW = 32;
    localparam int LN = 4;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic            clear = 1'b0;
    logic            vin = 1'b0;
    logic            rdy_o;
    logic [LN*DW-1:0] din = '0;
    logic            vout;
    logic            rdy_i = 1'b1;
    logic [LN*10-1:0] cls;
    logic [LN*DW-1:0] dout;
    logic [9:0]      sticky;
    logic [CW-1:0]   nan_cnt;
    logic [CW-1:0]   sub_cnt;

    int n_cmp = 0;
    int n_err = 0;

    iob_fp_classify_stream #(
        .DATA_W(DW), .EXP_W(8), .LANES(LN), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .arst_n_i(arst_n), .clear_i(clear),
        .valid_i(vin), .ready_o(rdy_o), .data_i(din),
        .valid_o(vout), .ready_i(rdy_i), .class_o(cls),
        .data_o(dout), .sticky_o(sticky),
        .nan_cnt_o(nan_cnt), .sub_cnt_o(sub_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] ec(input int v);
        return EN ? CW'(v) : '0;
    endfunction

    localparam logic [31:0] ONE = 32'h3F800000;

    logic [31:0] dv [12];
    logic [9:0]  dc [12];
    logic [127:0] beat_a, beat_b, beat_e;

    initial begin
        dv = '{32'h3F800000, 32'hBF800000, 32'h00000001, 32'h80000001,
               32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
               32'h7F800001, 32'hFFC00000, 32'h7F7FFFFF, 32'h007FFFFF};
        dc = '{10'h040, 10'h002, 10'h020, 10'h004, 10'h010, 10'h008,
               10'h080, 10'h001, 10'h100, 10'h200, 10'h040, 10'h020};

        // reset state
        #3;
        chk("rst_valid", vout, 0);
        chk("rst_class", cls, 0);
        chk("rst_data", dout, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_nan", nan_cnt, 0);
        chk("rst_sub", sub_cnt, 0);
        chk("rst_ready", rdy_o, 1);
        #9 arst_n = 1'b1;
        tick();

        // decode: test operand in lane 0, +1.0 in the others
        for (int i = 0; i < 12; i++) begin
            vin = 1'b1;
            din = {ONE, ONE, ONE, dv[i]};
            tick();
            chk($sformatf("dec_class_%0d", i), cls,
                {10'h040, 10'h040, 10'h040, dc[i]});
            chk($sformatf("dec_data_%0d", i), dout[31:0], dv[i]);
            chk($sformatf("dec_valid_%0d", i), vout, 1);
        end
        vin = 1'b0;
        din = {4{32'hDEADBEEF}};
        tick();
        chk("idle_valid", vout, 0);
        chk("idle_data_hold", dout[31:0], 32'h007FFFFF);
        chk("dec_sticky", sticky, 10'h3FF);
        chk("dec_nan", nan_cnt, ec(2));
        chk("dec_sub", sub_cnt, ec(3));

        // clear with simultaneous accept
        clear = 1'b1;
        vin = 1'b1;
        din = {ONE, ONE, 32'h7F800001, 32'h00000001};
        tick();
        chk("clracc_sticky", sticky, 10'h160);
        chk("clracc_nan", nan_cnt, ec(1));
        chk("clracc_sub", sub_cnt, ec(1));

        // clear alone
        vin = 1'b0;
        tick();
        chk("clr_sticky", sticky, 0);
        chk("clr_nan", nan_cnt, 0);
        chk("clr_sub", sub_cnt, 0);
        clear = 1'b0;

        // counter saturation
        for (int i = 0; i < 5; i++) begin
            vin = 1'b1;
            din = {4{32'h7FC00000}};
            tick();
            chk($sformatf("sat_nan_%0d", i), nan_cnt,
                ec(i < 3 ? 4 * (i + 1) : 15));
            chk($sformatf("sat_class_%0d", i), cls, {4{10'h200}});
        end
        vin = 1'b0;
        tick();
        chk("sat_hold", nan_cnt, ec(15));
        chk("sat_sticky", sticky, 10'h200);
        chk("sat_sub", sub_cnt, 0);

        // backpressure
        beat_a = {32'h7F800000, 32'h00000000, 32'hBF800000, ONE};
        beat_b = {32'hFF800000, 32'h80000000, 32'h80000001, 32'hFFC00000};
        rdy_i = 1'b0;
        vin = 1'b1;
        din = beat_a;
        #1;
        chk("bp_ready_pre", rdy_o, 1);
        tick();
        chk("bp_ready_drop", rdy_o, 0);
        chk("bp_valid", vout, 1);
        chk("bp_class_a", cls, {10'h080, 10'h010, 10'h002, 10'h040});
        chk("bp_sticky_a", sticky, 10'h2D2);
        din = beat_b;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("bp_hold_data_%0d", i), dout, beat_a);
            chk($sformatf("bp_hold_class_%0d", i), cls,
                {10'h080, 10'h010, 10'h002, 10'h040});
            chk($sformatf("bp_hold_sub_%0d", i), sub_cnt, 0);
        end
        rdy_i = 1'b1;
        #1;
        chk("bp_ready_comb", rdy_o, 1);
        tick();
        chk("bp_data_b", dout, beat_b);
        chk("bp_class_b", cls, {10'h001, 10'h008, 10'h004, 10'h200});
        chk("bp_sub_b", sub_cnt, ec(1));
        vin = 1'b0;
        tick();
        chk("bp_drain_valid", vout, 0);
        chk("bp_drain_data", dout, beat_b);
        chk("bp_sub_once", sub_cnt, ec(1));

        // async reset while a beat is held
        rdy_i = 1'b0;
        vin = 1'b1;
        din = beat_a;
        tick();
        chk("ar_valid_pre", vout, 1);
        vin = 1'b0;
        #1 arst_n = 1'b0;
        #1;
        chk("ar_valid", vout, 0);
        chk("ar_class", cls, 0);
        chk("ar_data", dout, 0);
        chk("ar_sticky", sticky, 0);
        chk("ar_nan", nan_cnt, 0);
        chk("ar_sub", sub_cnt, 0);
        #1 arst_n = 1'b1;
        #1;
        chk("ar_ready", rdy_o, 1);
        beat_e = {ONE, ONE, ONE, 32'h00000001};
        rdy_i = 1'b1;
        vin = 1'b1;
        din = beat_e;
        tick();
        chk("ar_lat_valid", vout, 1);
        chk("ar_lat_data", dout, beat_e);
        chk("ar_lat_class", cls, {10'h040, 10'h040, 10'h040, 10'h020});
        chk("ar_lat_sticky", sticky, 10'h060);
        chk("ar_lat_sub", sub_cnt, ec(1));
        vin = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
